// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream and imem write-port bundle for imem_loader.
//   i_byte / i_byte_valid  host byte and its valid qualifier (host -> loader)
//   o_byte_ready           loader can take i_byte this cycle  (loader -> host)
//   o_imem_we              one-cycle imem write strobe        (loader -> imem)
//   o_imem_addr            imem word address                  (loader -> imem)
//   o_imem_wdata           little-endian packed 32-bit word   (loader -> imem)
// master: host/memory side. slave: the loader.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 10
) ();
  logic [7:0]        i_byte;
  logic              i_byte_valid;
  logic              o_byte_ready;
  logic              o_imem_we;
  logic [ADDR_W-1:0] o_imem_addr;
  logic [31:0]       o_imem_wdata;

  modport master (
    output i_byte,
    output i_byte_valid,
    input  o_byte_ready,
    input  o_imem_we,
    input  o_imem_addr,
    input  o_imem_wdata
  );

  modport slave (
    input  i_byte,
    input  i_byte_valid,
    output o_byte_ready,
    output o_imem_we,
    output o_imem_addr,
    output o_imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: loads a framed byte stream into the core's instruction memory.
// Frame: MAGIC, CNT_LO, CNT_HI, N x 4 payload bytes (LSB first), CSUM (8-bit sum of payload).
// Words go to imem addresses 0..N-1; the core is released from reset only after a frame
// with a matching checksum. A MAGIC byte in DONE/ERR starts a reload.
// Ports:
//   i_clk       system clock
//   i_rst       synchronous active-high reset
//   bus         imem_loader_if.slave (byte stream in, imem write port out)
//   o_core_rst  core reset, high until a frame loads cleanly
//   o_done      frame loaded and checksum matched
//   o_err       frame rejected (bad count or bad checksum)
module imem_loader #(
  parameter int unsigned ADDR_W = 10,
  parameter logic [7:0]  MAGIC  = 8'hA5
) (
  input  logic         i_clk,
  input  logic         i_rst,
  imem_loader_if.slave bus,
  output logic         o_core_rst,
  output logic         o_done,
  output logic         o_err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CNT_LO = 3'd1;
  localparam logic [2:0] CNT_HI = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] WRITE  = 3'd4;
  localparam logic [2:0] CSUM   = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;
  localparam logic [2:0] ERR    = 3'd7;

  // Capacity in words; a 17-bit compare keeps N == 2^ADDR_W legal for ADDR_W up to 16.
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  logic [2:0]        state_q, state_d;
  logic [7:0]        cnt_lo_q, cnt_lo_d;
  logic [15:0]       n_q, n_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        k_q, k_d;
  logic [31:0]       word_q, word_d;
  logic [7:0]        csum_q, csum_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              core_rst_q, core_rst_d;

  logic              accept;
  logic [15:0]       n_hdr;
  logic              last_word;

  // we_q is high exactly in WRITE, so it doubles as the not-ready flag.
  assign accept    = bus.i_byte_valid & ~we_q;
  assign n_hdr     = {bus.i_byte, cnt_lo_q};
  assign last_word = (17'(addr_q) + 17'd1) == {1'b0, n_q};

  always_comb begin
    state_d    = state_q;
    cnt_lo_d   = cnt_lo_q;
    n_d        = n_q;
    addr_d     = addr_q;
    k_d        = k_q;
    word_d     = word_q;
    csum_d     = csum_q;
    we_d       = 1'b0;
    done_d     = done_q;
    err_d      = err_q;
    core_rst_d = core_rst_q;

    case (state_q)
      IDLE: begin
        if (accept && bus.i_byte == MAGIC) begin
          state_d = CNT_LO;
          csum_d  = 8'd0;
        end
      end
      CNT_LO: begin
        if (accept) begin
          cnt_lo_d = bus.i_byte;
          state_d  = CNT_HI;
        end
      end
      CNT_HI: begin
        if (accept) begin
          n_d    = n_hdr;
          csum_d = 8'd0;
          addr_d = '0;
          k_d    = 2'd0;
          if (n_hdr == 16'd0) begin
            state_d = CSUM;
          end else if ({1'b0, n_hdr} > MAX_WORDS) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          word_d[8*k_q +: 8] = bus.i_byte;
          csum_d             = csum_q + bus.i_byte;
          k_d                = k_q + 2'd1;
          if (k_q == 2'd3) begin
            state_d = WRITE;
            we_d    = 1'b1;
          end
        end
      end
      WRITE: begin
        // The address holds on the final word so it can never wrap to 0.
        if (last_word) begin
          state_d = CSUM;
        end else begin
          state_d = DATA;
          addr_d  = addr_q + ADDR_W'(1);
        end
      end
      CSUM: begin
        if (accept) begin
          if (bus.i_byte == csum_q) begin
            state_d    = DONE;
            done_d     = 1'b1;
            core_rst_d = 1'b0;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
      end
      DONE, ERR: begin
        if (accept && bus.i_byte == MAGIC) begin
          state_d    = CNT_LO;
          done_d     = 1'b0;
          err_d      = 1'b0;
          core_rst_d = 1'b1;
          csum_d     = 8'd0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      cnt_lo_q   <= 8'd0;
      n_q        <= 16'd0;
      addr_q     <= '0;
      k_q        <= 2'd0;
      word_q     <= 32'd0;
      csum_q     <= 8'd0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      core_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_lo_q   <= cnt_lo_d;
      n_q        <= n_d;
      addr_q     <= addr_d;
      k_q        <= k_d;
      word_q     <= word_d;
      csum_q     <= csum_d;
      we_q       <= we_d;
      done_q     <= done_d;
      err_q      <= err_d;
      core_rst_q <= core_rst_d;
    end
  end

  assign bus.o_byte_ready = ~we_q;
  assign bus.o_imem_we    = we_q;
  assign bus.o_imem_addr  = addr_q;
  assign bus.o_imem_wdata = word_q;
  assign o_core_rst       = core_rst_q;
  assign o_done           = done_q;
  assign o_err            = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader (ADDR_W=10).
module tb_imem_loader;
  localparam int unsigned AW    = 10;
  localparam logic [7:0]  MAGIC = 8'hA5;

  logic i_clk = 1'b0;
  logic i_rst;
  logic o_core_rst, o_done, o_err;

  always #5 i_clk = ~i_clk;

  imem_loader_if #(.ADDR_W(AW)) bif ();

  imem_loader #(.ADDR_W(AW), .MAGIC(MAGIC)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .bus        (bif),
    .o_core_rst (o_core_rst),
    .o_done     (o_done),
    .o_err      (o_err)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0]    payload_q[$];
  logic [AW+31:0] exp_q[$];
  logic           prev_we = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe is matched against the oldest expected write.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      check("ready_vs_we", 64'(bif.o_byte_ready), 64'(!bif.o_imem_we));
      if (bif.o_imem_we) begin
        check("we_single_cycle", 64'(prev_we), 64'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: addr %0h data %0h", bif.o_imem_addr, bif.o_imem_wdata);
        end else begin
          logic [AW+31:0] e;
          e = exp_q.pop_front();
          check("wr_addr", 64'(bif.o_imem_addr), 64'(e[AW+31:32]));
          check("wr_data", 64'(bif.o_imem_wdata), 64'(e[31:0]));
        end
      end
    end
    prev_we = bif.o_imem_we;
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int g;
    int guard;
    g = 0;
    if (gaps) begin
      while ($urandom_range(1, 0) == 1 && g < 6) begin
        bif.i_byte_valid = 1'b0;
        bif.i_byte       = 8'($urandom);
        @(posedge i_clk); #1;
        g++;
      end
    end
    bif.i_byte       = b;
    bif.i_byte_valid = 1'b1;
    guard = 0;
    while (!bif.o_byte_ready && guard < 20) begin
      @(posedge i_clk); #1;
      guard++;
    end
    if (guard >= 20) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got ready=0 expected ready=1");
    end
    @(posedge i_clk); #1;
    bif.i_byte_valid = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_core_rst", 64'(o_core_rst), 64'd1);
    check("rst_we", 64'(bif.o_imem_we), 64'd0);
    check("rst_addr", 64'(bif.o_imem_addr), 64'd0);
    check("rst_wdata", 64'(bif.o_imem_wdata), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    check("rst_err", 64'(o_err), 64'd0);
    check("rst_ready", 64'(bif.o_byte_ready), 64'd1);
  endtask

  task automatic apply_reset();
    @(negedge i_clk); #1;
    bif.i_byte_valid = 1'b0;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
  endtask

  // Sends a frame built from payload_q; expected writes are pushed as each word's 4th byte
  // goes out. stop_words >= 0 abandons the frame after that many words.
  task automatic load_frame(input logic [15:0] n, input int csum_delta, input bit gaps,
                            input int stop_words);
    logic [7:0] sum;
    logic [7:0] b;
    bit ok;
    sum = 8'd0;
    send_byte(MAGIC, gaps);
    check("reload_done", 64'(o_done), 64'd0);
    check("reload_err", 64'(o_err), 64'd0);
    check("reload_core_rst", 64'(o_core_rst), 64'd1);
    send_byte(n[7:0], gaps);
    send_byte(n[15:8], gaps);
    if (32'(n) > (32'd1 << AW)) begin
      check("oversize_err", 64'(o_err), 64'd1);
      check("oversize_done", 64'(o_done), 64'd0);
      check("oversize_core_rst", 64'(o_core_rst), 64'd1);
      return;
    end
    for (int i = 0; i < int'(n); i++) begin
      if (i == stop_words) return;
      for (int j = 0; j < 4; j++) begin
        b   = payload_q[i][8*j +: 8];
        sum = sum + b;
        send_byte(b, gaps);
      end
      exp_q.push_back({AW'(i), payload_q[i]});
      check("we_rises_after_4th", 64'(bif.o_imem_we), 64'd1);
    end
    check("core_rst_before_csum", 64'(o_core_rst), 64'd1);
    send_byte(sum + 8'(csum_delta), gaps);
    ok = (csum_delta == 0);
    check("csum_done", 64'(o_done), 64'(ok));
    check("csum_err", 64'(o_err), 64'(!ok));
    check("csum_core_rst", 64'(o_core_rst), 64'(!ok));
    repeat (3) @(posedge i_clk);
    #1;
    check("writes_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic random_payload(input int n);
    payload_q.delete();
    for (int i = 0; i < n; i++) payload_q.push_back($urandom);
  endtask

  initial begin
    i_rst            = 1'b1;
    bif.i_byte       = 8'd0;
    bif.i_byte_valid = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    check_reset_values();

    // Two-word frame, good then bad checksum.
    payload_q = '{32'h00500013, 32'h00100093};
    load_frame(16'd2, 0, 1'b0, -1);
    load_frame(16'd2, 1, 1'b0, -1);

    // Leading non-MAGIC bytes are ignored while in ERR.
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h12, 1'b0);
    check("garbage_keeps_err", 64'(o_err), 64'd1);
    payload_q = '{32'h44332211};
    load_frame(16'd1, 0, 1'b0, -1);

    // Empty frame, then one count past capacity.
    payload_q.delete();
    load_frame(16'd0, 0, 1'b0, -1);
    load_frame(16'd1025, 0, 1'b0, -1);

    // 16 words with random valid gaps.
    random_payload(16);
    load_frame(16'd16, 0, 1'b1, -1);

    // Reset after 2 of 3 words; then a clean 1-word load.
    random_payload(3);
    load_frame(16'd3, 0, 1'b0, 2);
    apply_reset();
    check("abandon_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    check_reset_values();
    random_payload(1);
    load_frame(16'd1, 0, 1'b0, -1);

    // Random frames, random checksum corruption and gaps.
    for (int f = 0; f < 6; f++) begin
      int n;
      int d;
      n = int'($urandom_range(6, 1));
      d = ($urandom_range(2, 0) == 0) ? int'($urandom_range(255, 1)) : 0;
      random_payload(n);
      load_frame(16'(n), d, 1'($urandom_range(1, 0)), -1);
    end

    // Full capacity: last write lands at 1023 and nothing wraps to 0.
    random_payload(1 << AW);
    load_frame(16'(1 << AW), 0, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
